// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the rr_arbiter4 round-robin arbiter.
// Replaces the rr_arb_defs.vh header: holds the state encodings and the hold counter width.
package rr_arbiter4_pkg;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int ARB_CNT_W = 8;
  localparam int NUM_REQ   = 4;

  // Rotate right so that bit 'sh' of r lands in bit 0 (search start position).
  function automatic logic [NUM_REQ-1:0] rot_right4(input logic [NUM_REQ-1:0] r,
                                                    input logic [1:0] sh);
    logic [2*NUM_REQ-1:0] w;
    w = {r, r} >> sh;
    return w[NUM_REQ-1:0];
  endfunction
endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       y1;
  logic       y0;
  logic       v;

  modport master (output req, input gnt, y1, y0, v);
  modport slave  (input req, output gnt, y1, y0, v);
endinterface

// File: rtl/rr_arbiter4_four_to_two_prio_enc.sv
// Combinational fixed-priority 4-to-2 encoder; input a (bit 0) has highest priority.
module four_to_two_prio_enc (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  input  logic i_d,
  output logic o_y1,
  output logic o_y0,
  output logic o_v
);
  assign o_v  = i_a | i_b | i_c | i_d;
  assign o_y1 = ~i_a & ~i_b & (i_c | i_d);
  assign o_y0 = ~i_a & (i_b | (~i_c & i_d));
endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot and encoded grant outputs.
// Optional owner pre-emption after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input logic          clk,
  input logic          rst_n,
  rr_arbiter4_if.slave arb
);
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_arbiter4: MAX_HOLD out of range 2..255");
  end

  arb_state_e r_state, w_state_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic [1:0] r_y, w_y_nxt;

  logic       w_rel, w_tmo, w_rearb;
  logic [1:0] w_sptr, w_win;
  logic [3:0] w_rot;
  logic       w_ey1, w_ey0, w_ev;

  // r_y is the owner index while in GRANT (y holds the last index when idle)
  assign w_rel   = (r_state == ST_GRANT) && !arb.req[r_y];
  assign w_rearb = w_rel | w_tmo;
  assign w_sptr  = w_rearb ? r_y + 2'd1 : r_ptr;
  assign w_rot   = rot_right4(arb.req, w_sptr);

  four_to_two_prio_enc u_enc (
    .i_a (w_rot[0]),
    .i_b (w_rot[1]),
    .i_c (w_rot[2]),
    .i_d (w_rot[3]),
    .o_y1(w_ey1),
    .o_y0(w_ey0),
    .o_v (w_ev)
  );

  assign w_win = {w_ey1, w_ey0} + w_sptr;

`ifdef ARB_TIMEOUT_EN
  localparam logic [ARB_CNT_W-1:0] CNT_MAX = ARB_CNT_W'(MAX_HOLD - 1);
  logic [ARB_CNT_W-1:0] r_cnt;
  logic                 w_new_grant;

  assign w_tmo       = (r_state == ST_GRANT) && (r_cnt == CNT_MAX) && |(arb.req & ~r_gnt);
  assign w_new_grant = w_ev && ((r_state == ST_IDLE) || w_rearb);

  // Saturates at CNT_MAX so a lone owner keeps re-checking for contenders every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        r_cnt <= '0;
    else if (w_new_grant)                              r_cnt <= '0;
    else if (r_state == ST_GRANT && r_cnt != CNT_MAX)  r_cnt <= r_cnt + 1'b1;
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_gnt   <= 4'b0000;
      r_y     <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_y     <= w_y_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_y_nxt     = r_y;
    case (r_state)
      ST_IDLE: begin
        if (w_ev) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = 4'(4'b0001 << w_win);
          w_y_nxt     = w_win;
        end
      end
      ST_GRANT: begin
        if (w_rearb) begin
          w_ptr_nxt = w_sptr;
          if (w_ev) begin
            w_gnt_nxt = 4'(4'b0001 << w_win);
            w_y_nxt   = w_win;
          end else begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = 4'b0000;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign arb.gnt = r_gnt;
  assign arb.y1  = r_y[1];
  assign arb.y0  = r_y[0];
  assign arb.v   = (r_state == ST_GRANT);
endmodule
